// File: rtl/ofm_writeback.sv
// ofm_writeback: captures activated PE-cluster results, buffers them in a
// two-entry FIFO and writes them to OFM memory as 32-bit words in
// channel-last order, with frame-done detection.
module ofm_writeback #(
    parameter int LANES      = 16,
    parameter int FIFO_DEPTH = 2,
    parameter int ADDR_W     = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [7:0]         OFM_W,
    input  logic [7:0]         OFM_C,
    input  logic [ADDR_W-1:0]  base_addr,
    input  logic [LANES-1:0]   valid_in,
    input  logic [LANES*8-1:0] ofm_data,
    output logic               wr_en,
    output logic [ADDR_W-1:0]  wr_addr,
    output logic [31:0]        wr_data,
    output logic               busy,
    output logic               done,
    output logic               overflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    logic [LANES*8-1:0] fifo_mem [FIFO_DEPTH];
    logic               rd_ptr;
    logic               wr_ptr;
    logic [1:0]         count;

    logic [7:0]         cfg_w;
    logic [3:0]         cfg_tiles;
    logic [ADDR_W-1:0]  cfg_base;
    logic [ADDR_W-1:0]  cfg_stride;

    logic [1:0]         word;
    logic [7:0]         col;
    logic [7:0]         row;
    logic [3:0]         tile;
    logic [ADDR_W-1:0]  pixel_base;
    logic [ADDR_W-1:0]  tile_off;

    logic               push;
    logic               pop;
    logic               drop;
    logic               drain;
    logic               done_set;
    logic               last_pixel;
    logic               last_tile;
    logic [LANES*8-1:0] head_entry;
    logic [31:0]        head_word;
    logic [3:0]         tiles_in;

    assign busy       = (state == RUN);
    assign last_pixel = (col == cfg_w - 8'd1) && (row == cfg_w - 8'd1);
    assign last_tile  = (tile == cfg_tiles - 4'd1);
    assign head_entry = fifo_mem[rd_ptr];
    assign head_word  = head_entry[32*word +: 32];
    assign tiles_in   = (OFM_C[7:4] == 4'd0) ? 4'd1 : OFM_C[7:4];

    // State register; start and frame end are decided in the next-state logic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state plus per-cycle FIFO push/pop/drop and drain decisions.
    always_comb begin
        next_state = state;
        push       = 1'b0;
        pop        = 1'b0;
        drop       = 1'b0;
        drain      = 1'b0;
        done_set   = 1'b0;
        if (start) begin
            next_state = (OFM_W == 8'd0) ? IDLE : RUN;
            done_set   = (OFM_W == 8'd0);
        end else begin
            case (state)
                IDLE: begin
                    next_state = IDLE;
                end
                RUN: begin
                    drain = (count != 2'd0);
                    pop   = drain && (word == 2'd3);
                    if (pop && last_pixel && last_tile) begin
                        next_state = DONE;
                    end
                    if (|valid_in) begin
                        if ((count != 2'd2) || pop) begin
                            push = 1'b1;
                        end else begin
                            drop = 1'b1;
                        end
                    end
                end
                DONE: begin
                    next_state = IDLE;
                    done_set   = 1'b1;
                end
                default: begin
                    next_state = IDLE;
                end
            endcase
        end
    end

    // Capture storage; entries need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= ofm_data;
        end
    end

    // Config latch, FIFO bookkeeping, address generation and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            done       <= 1'b0;
            overflow   <= 1'b0;
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
            count      <= 2'd0;
            cfg_w      <= 8'd0;
            cfg_tiles  <= 4'd1;
            cfg_base   <= '0;
            cfg_stride <= '0;
            word       <= 2'd0;
            col        <= 8'd0;
            row        <= 8'd0;
            tile       <= 4'd0;
            pixel_base <= '0;
            tile_off   <= '0;
        end else begin
            done <= done_set;
            if (start) begin
                cfg_w      <= OFM_W;
                cfg_tiles  <= tiles_in;
                cfg_base   <= base_addr;
                cfg_stride <= ADDR_W'(OFM_C[7:2]);
                wr_en      <= 1'b0;
                overflow   <= 1'b0;
                rd_ptr     <= 1'b0;
                wr_ptr     <= 1'b0;
                count      <= 2'd0;
                word       <= 2'd0;
                col        <= 8'd0;
                row        <= 8'd0;
                tile       <= 4'd0;
                pixel_base <= base_addr;
                tile_off   <= '0;
            end else begin
                wr_en <= drain;
                if (drain) begin
                    wr_data <= head_word;
                    wr_addr <= pixel_base + tile_off + ADDR_W'(word);
                    word    <= word + 2'd1;
                end
                if (pop) begin
                    rd_ptr <= ~rd_ptr;
                    if (last_pixel) begin
                        col        <= 8'd0;
                        row        <= 8'd0;
                        tile       <= tile + 4'd1;
                        pixel_base <= cfg_base;
                        tile_off   <= tile_off + ADDR_W'(4);
                    end else begin
                        pixel_base <= pixel_base + cfg_stride;
                        if (col == cfg_w - 8'd1) begin
                            col <= 8'd0;
                            row <= row + 8'd1;
                        end else begin
                            col <= col + 8'd1;
                        end
                    end
                end
                if (push) begin
                    wr_ptr <= ~wr_ptr;
                end
                if (push && !pop) begin
                    count <= count + 2'd1;
                end else if (pop && !push) begin
                    count <= count - 2'd1;
                end
                if (drop) begin
                    overflow <= 1'b1;
                end
            end
        end
    end

endmodule
